// File: rtl/i2c_pkg.sv
// Shared constants for the I2C register-burst reader.
// Holds FSM encoding, status codes and burst-length helper.
package i2c_pkg;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_SPACE = 3'd1;
    localparam logic [2:0] S_ISSUE      = 3'd2;
    localparam logic [2:0] S_WAIT_BUSY  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE  = 3'd4;
    localparam logic [2:0] S_FINISH     = 3'd5;

    localparam logic [3:0] STATUS_OK   = 4'h0;
    localparam logic [3:0] ERR_TIMEOUT = 4'hF;

    // A requested count of zero stands for a full 256-register sweep.
    function automatic logic [8:0] burst_len(input logic [7:0] c);
        return (c == 8'd0) ? 9'd256 : {1'b0, c};
    endfunction

endpackage

// File: rtl/i2c_read_seq_if.sv
// Bus bundle between the sequencer, the I2C master and the consumer.
// master: sequencer side; slave: master-model / consumer side.
interface i2c_read_seq_if #(
    parameter int DATA_W = 16
);
    logic              m_read_en;
    logic [6:0]        m_chip_addr;
    logic [7:0]        m_reg_addr;
    logic              m_busy;
    logic              m_done;
    logic [3:0]        m_status;
    logic [DATA_W-1:0] m_data_out;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        rd_addr;

    modport master (
        output m_read_en, m_chip_addr, m_reg_addr,
        input  m_busy, m_done, m_status, m_data_out,
        output rd_valid, rd_data, rd_addr,
        input  rd_ready
    );

    modport slave (
        input  m_read_en, m_chip_addr, m_reg_addr,
        output m_busy, m_done, m_status, m_data_out,
        input  rd_valid, rd_data, rd_addr,
        output rd_ready
    );

endinterface

// File: rtl/i2c_read_fifo.sv
// Synchronous FIFO buffering {addr, data} read results.
// Output is forced to zero while empty so idle data is clean.
module i2c_read_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    // Pointer advance on accepted push / pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/i2c_read_seq.sv
// Burst register reader: issues one i2c_master read per register,
// buffers results in a FIFO and reports NACK / timeout errors.
module i2c_read_seq
    import i2c_pkg::*;
#(
    parameter int          DATA_W     = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [6:0]      chip_addr,
    input  logic [7:0]      base_addr,
    input  logic [7:0]      count,
    i2c_read_seq_if.master  bus,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [3:0]      err_code
);
    localparam int FW = DATA_W + 8;

    logic [2:0]    state_q, state_d;
    logic [6:0]    chip_q, chip_d;
    logic [7:0]    addr_q, addr_d;
    logic [8:0]    rem_q, rem_d;
    logic [15:0]   tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [3:0]    code_q, code_d;

    logic          push, pop;
    logic          fifo_full, fifo_empty;
    logic [FW-1:0] fifo_dout;

    // Next-state logic for the burst FSM and its counters.
    always_comb begin
        state_d = state_q;
        chip_d  = chip_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        code_d  = code_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    chip_d  = chip_addr;
                    addr_d  = base_addr;
                    rem_d   = burst_len(count);
                    err_d   = 1'b0;
                    code_d  = STATUS_OK;
                    state_d = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (!fifo_full) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY, S_WAIT_DONE: begin
                tmo_d = tmo_q + 16'd1;
                if (bus.m_done) begin
                    if (bus.m_status == STATUS_OK) begin
                        push    = 1'b1;
                        addr_d  = addr_q + 8'd1;
                        rem_d   = rem_q - 9'd1;
                        state_d = (rem_q == 9'd1) ? S_FINISH
                                                  : S_WAIT_SPACE;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = bus.m_status;
                        state_d = S_FINISH;
                    end
                end else if (tmo_q == TIMEOUT - 16'd1) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = S_FINISH;
                end else if (state_q == S_WAIT_BUSY && bus.m_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            chip_q  <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= STATUS_OK;
        end else begin
            state_q <= state_d;
            chip_q  <= chip_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign pop = bus.rd_ready && !fifo_empty;

    i2c_read_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (push),
        .din_i   ({addr_q, bus.m_data_out}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.m_read_en   = (state_q == S_ISSUE);
    assign bus.m_chip_addr = chip_q;
    assign bus.m_reg_addr  = addr_q;
    assign bus.rd_valid    = !fifo_empty;
    assign bus.rd_addr     = fifo_dout[FW-1:DATA_W];
    assign bus.rd_data     = fifo_dout[DATA_W-1:0];

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FINISH);
    assign error    = err_q;
    assign err_code = code_q;

endmodule

// File: tb/tb_i2c_read_seq.sv
// Bench for i2c_read_seq with a behavioural i2c_master/slave model.
// Expected read results are queued at stimulus time and popped on output.
module tb_i2c_read_seq;
    localparam int          DW    = 16;
    localparam int          DEPTH = 4;
    localparam logic [15:0] TMO   = 16'd40;
    localparam int          LAT   = 3;
    localparam logic [3:0]  NACK  = 4'h2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] chip_addr = '0;
    logic [7:0] base_addr = '0;
    logic [7:0] count = '0;
    logic       busy, done, error;
    logic [3:0] err_code;

    i2c_read_seq_if #(.DATA_W(DW)) bus();

    i2c_read_seq #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .chip_addr (chip_addr),
        .base_addr (base_addr),
        .count     (count),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          issue_cnt = 0;
    int          tick = 0;
    bit          mute = 1'b0;
    logic [15:0] regs [256];
    logic [23:0] exp_q [$];
    logic [23:0] e;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) tick++;

    // Master + slave model: chip 0x0F answers from regs, others NACK.
    initial begin : master_model
        logic [6:0] c;
        logic [7:0] r;
        bus.m_busy     = 1'b0;
        bus.m_done     = 1'b0;
        bus.m_status   = 4'h0;
        bus.m_data_out = '0;
        forever begin
            @(negedge clk);
            if (bus.m_read_en && !mute) begin
                c = bus.m_chip_addr;
                r = bus.m_reg_addr;
                @(negedge clk);
                bus.m_busy = 1'b1;
                repeat (LAT) @(negedge clk);
                bus.m_busy     = 1'b0;
                bus.m_done     = 1'b1;
                bus.m_status   = (c == 7'h0F) ? 4'h0 : NACK;
                bus.m_data_out = (c == 7'h0F) ? regs[r] : 16'h0;
                @(negedge clk);
                bus.m_done     = 1'b0;
                bus.m_status   = 4'h0;
                bus.m_data_out = '0;
            end
        end
    end

    // Output monitor and scoreboard compare.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (bus.m_read_en) issue_cnt++;
        if (!reset && bus.rd_valid && bus.rd_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexp_pop", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("rd_addr", 32'(bus.rd_addr), 32'(e[23:16]));
                chk("rd_data", 32'(bus.rd_data), 32'(e[15:0]));
            end
        end
    end

    task automatic go(input logic [6:0] c, input logic [7:0] b,
                      input logic [7:0] n);
        @(posedge clk);
        #1;
        chip_addr = c;
        base_addr = b;
        count     = n;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic expect_burst(input logic [7:0] b, input int n);
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + 8'(i);
            exp_q.push_back({a, regs[a]});
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic drain(input string tag, input int limit);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int i0;
        int t0;
        int k;
        int d0;
        for (int i = 0; i < 256; i++)
            regs[i] = {8'(i), ~8'(i)};
        regs[8'h0A] = 16'hA1A1;
        regs[8'h0B] = 16'hB2B2;
        regs[8'h0C] = 16'hC3C3;
        bus.rd_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_data", 32'(bus.rd_data), 32'd0);
        chk("rst_addr", 32'(bus.rd_addr), 32'd0);
        chk("rst_rden", 32'(bus.m_read_en), 32'd0);
        chk("rst_mchip", 32'(bus.m_chip_addr), 32'd0);
        chk("rst_mreg", 32'(bus.m_reg_addr), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic burst, consumer always ready
        bus.rd_ready = 1'b1;
        expect_burst(8'h0A, 3);
        go(7'h0F, 8'h0A, 8'd3);
        wait_done("b1_done", 200);
        chk("b1_err", 32'(error), 32'd0);
        chk("b1_code", 32'(err_code), 32'd0);
        @(negedge clk);
        chk("b1_idle", 32'(busy), 32'd0);
        drain("b1_drain", 20);

        // Consumer stalled: reads stop once the FIFO is full
        bus.rd_ready = 1'b0;
        i0 = issue_cnt;
        expect_burst(8'h0A, 6);
        go(7'h0F, 8'h0A, 8'd6);
        repeat (80) @(negedge clk);
        chk("stall_issues", 32'(issue_cnt - i0), 32'(DEPTH));
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_valid", 32'(bus.rd_valid), 32'd1);
        @(posedge clk);
        #1 bus.rd_ready = 1'b1;
        wait_done("b2_done", 300);
        drain("b2_drain", 20);
        chk("b2_issues", 32'(issue_cnt - i0), 32'd6);
        chk("b2_err", 32'(error), 32'd0);

        // Register address wraps 0xFF -> 0x00
        expect_burst(8'hFF, 2);
        go(7'h0F, 8'hFF, 8'd2);
        wait_done("wrap_done", 200);
        drain("wrap_drain", 20);
        chk("wrap_err", 32'(error), 32'd0);

        // Absent chip: NACK ends the burst, nothing buffered
        i0 = issue_cnt;
        go(7'h22, 8'h0A, 8'd2);
        wait_done("nack_done", 200);
        chk("nack_err", 32'(error), 32'd1);
        chk("nack_code", 32'(err_code), 32'(NACK));
        chk("nack_issues", 32'(issue_cnt - i0), 32'd1);
        repeat (3) @(negedge clk);
        chk("nack_valid", 32'(bus.rd_valid), 32'd0);

        // Silent master: timeout, with a mid-burst start ignored
        mute = 1'b1;
        i0 = issue_cnt;
        go(7'h0F, 8'h0A, 8'd1);
        t0 = tick;
        repeat (5) @(negedge clk);
        go(7'h0F, 8'h40, 8'd1);
        wait_done("tmo_done", 200);
        chk("tmo_len", 32'((tick - t0 >= int'(TMO)) &&
                           (tick - t0 <= int'(TMO) + 6)), 32'd1);
        chk("tmo_err", 32'(error), 32'd1);
        chk("tmo_code", 32'(err_code), 32'hF);
        chk("tmo_issues", 32'(issue_cnt - i0), 32'd1);
        chk("tmo_ign_start", 32'(bus.m_reg_addr), 32'h0A);
        chk("tmo_valid", 32'(bus.rd_valid), 32'd0);
        mute = 1'b0;

        // Reset while waiting for m_done
        go(7'h0F, 8'h0A, 8'd1);
        k = 0;
        while (!bus.m_busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rw_mbusy", 32'(bus.m_busy), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_done", 32'(done), 32'd0);
        chk("rw_error", 32'(error), 32'd0);
        chk("rw_code", 32'(err_code), 32'd0);
        chk("rw_valid", 32'(bus.rd_valid), 32'd0);
        chk("rw_rden", 32'(bus.m_read_en), 32'd0);
        chk("rw_mchip", 32'(bus.m_chip_addr), 32'd0);
        chk("rw_mreg", 32'(bus.m_reg_addr), 32'd0);
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rw_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rw_idle", 32'(busy), 32'd0);
        chk("rw_empty", 32'(bus.rd_valid), 32'd0);

        // Normal burst after the reset
        expect_burst(8'h0B, 2);
        go(7'h0F, 8'h0B, 8'd2);
        wait_done("post_done", 200);
        drain("post_drain", 20);
        chk("post_err", 32'(error), 32'd0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
